usb_fs_tx_pkt_buf: RTL

- Packet staging buffer that feeds the full-speed transmit serializer: endpoint logic writes one packet's payload bytes, commits it with a PID, and the block drives pkt_start/pid and serves the serializer's byte pull (tx_data_avail/tx_data_get/tx_data) until pkt_end.
- Sits between the IN-endpoint/protocol engine and the transmitter.
- All logic runs in the system clk domain; the serializer owns the 48 MHz crossing.

---
 rtl/usb_fs_pkg.sv | 25 ++
 rtl/usb_fs_tx_ram.sv | 34 +++
 rtl/usb_fs_tx_pkt_buf.sv | 138 +++++++++++++
 3 files changed

// File: rtl/usb_fs_pkg.sv
// Shared USB full-speed definitions: PID codes, TX buffer state encoding, DATA-PID test.
package usb_fs_pkg;

  localparam logic [3:0] PidOut   = 4'b0001;
  localparam logic [3:0] PidIn    = 4'b1001;
  localparam logic [3:0] PidSetup = 4'b1101;
  localparam logic [3:0] PidData0 = 4'b0011;
  localparam logic [3:0] PidData1 = 4'b1011;
  localparam logic [3:0] PidAck   = 4'b0010;
  localparam logic [3:0] PidNak   = 4'b1010;
  localparam logic [3:0] PidStall = 4'b1110;

  typedef enum logic [1:0] {
    StFill  = 2'd0,
    StStart = 2'd1,
    StSend  = 2'd2,
    StHold  = 2'd3
  } tx_state_e;

  // DATA0/DATA1/DATA2/MDATA all share 2'b11 in the low PID bits.
  function automatic logic is_data_pid(input logic [1:0] pid_lo);
    return pid_lo == 2'b11;
  endfunction

endpackage

// File: rtl/usb_fs_tx_ram.sv
// Byte RAM for the TX packet buffer: one write port, registered read port.
module usb_fs_tx_ram #(
  parameter int unsigned Depth = 64,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [7:0]       wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [7:0]       rdata_o
);

  logic [7:0] mem_q [Depth];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdata_q <= 8'h00;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/usb_fs_tx_pkt_buf.sv
// Single-packet TX staging buffer between endpoint logic and the FS serializer.
// Define USB_TX_RETRY_EN to hold the packet after EOP for retry/release.
module usb_fs_tx_pkt_buf
  import usb_fs_pkg::*;
#(
  parameter int unsigned Depth = 64,
  localparam int unsigned CntW = $clog2(Depth) + 1,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       wr_valid_i,
  input  logic [7:0] wr_data_i,
  output logic       wr_ready_o,
  input  logic       commit_i,
  input  logic [3:0] commit_pid_i,
  input  logic       abort_i,
  output logic       pkt_start_o,
  output logic [3:0] pid_o,
  output logic       tx_data_avail_o,
  input  logic       tx_data_get_i,
  output logic [7:0] tx_data_o,
  input  logic       pkt_end_i,
  output logic       busy_o,
  output logic       done_o,
  input  logic       retry_i,
  input  logic       release_i
);

  localparam logic [CntW-1:0] Full = CntW'(Depth);

`ifdef USB_TX_RETRY_EN
  localparam tx_state_e EndSt = StHold;
`else
  localparam tx_state_e EndSt = StFill;
  logic unused_retry;
  assign unused_retry = retry_i ^ release_i;
`endif

  tx_state_e       state_q, state_d;
  logic [CntW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CntW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]      pid_q, pid_d;
  logic            done_q, done_d;
  logic            commit_ok, wr_fire, get_fire, released, rewind;

  assign commit_ok = (state_q == StFill) && commit_i && !abort_i;
  assign wr_fire   = wr_valid_i && wr_ready_o && !abort_i;
  assign get_fire  = tx_data_get_i && tx_data_avail_o;
  assign released  = (state_q != StFill) && (state_d == StFill);
  assign rewind    = (state_q == StHold) && (state_d == StStart);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StFill;
      wr_cnt_q <= '0;
      rd_ptr_q <= '0;
      pid_q    <= 4'h0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_ptr_q <= rd_ptr_d;
      pid_q    <= pid_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill:  if (commit_ok) state_d = StStart;
      StStart: state_d = pkt_end_i ? EndSt : StSend;
      StSend:  if (pkt_end_i) state_d = EndSt;
      StHold: begin
`ifdef USB_TX_RETRY_EN
        if (release_i) state_d = StFill;
        else if (retry_i) state_d = StStart;
`else
        state_d = StFill;
`endif
      end
      default: state_d = StFill;
    endcase
  end

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_ptr_d = rd_ptr_q;
    pid_d    = pid_q;
    done_d   = released;
    if (state_q == StFill) begin
      if (abort_i) wr_cnt_d = '0;
      else if (wr_fire) wr_cnt_d = wr_cnt_q + CntW'(1);
      if (commit_ok) begin
        pid_d    = commit_pid_i;
        rd_ptr_d = '0;
      end
    end else if (released) begin
      wr_cnt_d = '0;
    end
    if (get_fire) rd_ptr_d = rd_ptr_q + CntW'(1);
    if (rewind) rd_ptr_d = '0;
  end

  always_comb begin
    wr_ready_o      = 1'b0;
    pkt_start_o     = 1'b0;
    tx_data_avail_o = 1'b0;
    busy_o          = 1'b1;
    unique case (state_q)
      StFill: begin
        wr_ready_o = (wr_cnt_q != Full);
        busy_o     = 1'b0;
      end
      StStart: pkt_start_o = 1'b1;
      StSend:  tx_data_avail_o = is_data_pid(pid_q[1:0]) && (rd_ptr_q != wr_cnt_q);
      default: ;
    endcase
  end

  assign pid_o  = pid_q;
  assign done_o = done_q;

  // Read address follows the next pointer so tx_data lands with the pointer update.
  usb_fs_tx_ram #(
    .Depth(Depth)
  ) u_ram (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .we_i   (wr_fire),
    .waddr_i(wr_cnt_q[AddrW-1:0]),
    .wdata_i(wr_data_i),
    .raddr_i(rd_ptr_d[AddrW-1:0]),
    .rdata_o(tx_data_o)
  );

endmodule
